// File: rtl/snake_game_controller_if.sv
// Signal bundle between the debounced button/collision sources and the snake game
// controller. The controller takes the slave side; the stimulus/source takes master.
interface snake_game_controller_if #(
    parameter int SCORE_W = 8
);
    logic [4:0]         in_btn;
    logic               in_food;
    logic               in_collision;
    logic               out_update_tick;
    logic               out_snake_reset;
    logic [4:0]         out_direction;
    logic [1:0]         out_state;
    logic [SCORE_W-1:0] out_score;

    modport master (
        output in_btn,
        output in_food,
        output in_collision,
        input  out_update_tick,
        input  out_snake_reset,
        input  out_direction,
        input  out_state,
        input  out_score
    );

    modport slave (
        input  in_btn,
        input  in_food,
        input  in_collision,
        output out_update_tick,
        output out_snake_reset,
        output out_direction,
        output out_state,
        output out_score
    );
endinterface

// File: rtl/snake_game_controller.sv
// Game sequencer for snake_logic: state machine, update strobe generation, filtered
// direction changes (one turn per step, no reversal), speed-up on food, freeze on collision.
module snake_game_controller #(
    parameter int TICK_W     = 26,
    parameter int TICK_START = 25_000_000,
    parameter int TICK_MIN   = 5_000_000,
    parameter int TICK_STEP  = 1_000_000,
    parameter int SCORE_W    = 8
) (
    input logic                    in_clock,
    input logic                    in_reset_n,
    snake_game_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [TICK_W-1:0]  P_START   = TICK_W'(TICK_START);
    localparam logic [TICK_W-1:0]  P_MIN     = TICK_W'(TICK_MIN);
    localparam logic [TICK_W-1:0]  P_STEP    = TICK_W'(TICK_STEP);
    localparam logic [TICK_W-1:0]  T_ONE     = TICK_W'(1);
    localparam logic [TICK_W:0]    P_FLOOR   = (TICK_W+1)'(TICK_MIN) + (TICK_W+1)'(TICK_STEP);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] S_ONE     = SCORE_W'(1);

    state_t              state_q, state_d;
    logic [4:0]          btn_prev_q;
    logic [TICK_W-1:0]   counter_q, counter_d;
    logic [TICK_W-1:0]   period_q, period_d;
    logic [TICK_W-1:0]   period_food;
    logic [4:0]          pending_q, pending_d;
    logic [4:0]          dir_q, dir_d;
    logic                tick_q, tick_d;
    logic [SCORE_W-1:0]  score_q, score_d;

    logic [4:0]          btn_edge;
    logic [4:0]          dir_edge;
    logic [4:0]          dir_opp;
    logic                centre_edge;
    logic                dir_ok;
    logic                fire;

    // Button edges, direction priority and the reversal filter against the applied heading.
    always_comb begin
        btn_edge    = bus.in_btn & ~btn_prev_q;
        centre_edge = btn_edge[0];
        dir_edge    = '0;
        if (btn_edge[1])      dir_edge = 5'b00010;
        else if (btn_edge[2]) dir_edge = 5'b00100;
        else if (btn_edge[3]) dir_edge = 5'b01000;
        else if (btn_edge[4]) dir_edge = 5'b10000;
        dir_opp = {dir_q[3], dir_q[4], dir_q[1], dir_q[2], 1'b0};
        dir_ok  = (dir_edge != '0) && (dir_edge != dir_q) && ((dir_edge & dir_opp) == '0);
        period_food = ({1'b0, period_q} >= P_FLOOR) ? (period_q - P_STEP) : P_MIN;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        period_d  = period_q;
        pending_d = pending_q;
        dir_d     = dir_q;
        tick_d    = 1'b0;
        score_d   = score_q;
        fire      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (centre_edge) begin
                    state_d   = ST_PLAY;
                    dir_d     = 5'b10000;
                    pending_d = '0;
                end
            end

            ST_PLAY: begin
                if (bus.in_collision) begin
                    state_d   = ST_OVER;
                    counter_d = '0;
                    pending_d = '0;
                end else begin
                    if (bus.in_food) begin
                        score_d  = (score_q == SCORE_MAX) ? score_q : score_q + S_ONE;
                        period_d = period_food;
                    end
                    if (centre_edge) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (dir_ok) pending_d = dir_edge;
                        // Compare against the post-food period so a shortened period that
                        // the counter has already reached fires on the very next cycle.
                        fire = (counter_q >= period_d - T_ONE);
                        if (fire) begin
                            tick_d    = 1'b1;
                            counter_d = '0;
                            if (pending_d != '0) dir_d = pending_d;
                            pending_d = '0;
                        end else begin
                            counter_d = counter_q + T_ONE;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (centre_edge) state_d = ST_PLAY;
            end

            ST_OVER: begin
                counter_d = '0;
                if (centre_edge) begin
                    state_d   = ST_IDLE;
                    score_d   = '0;
                    period_d  = P_START;
                    dir_d     = '0;
                    pending_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q    <= ST_IDLE;
            btn_prev_q <= '0;
            counter_q  <= '0;
            period_q   <= P_START;
            pending_q  <= '0;
            dir_q      <= '0;
            tick_q     <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= bus.in_btn;
            counter_q  <= counter_d;
            period_q   <= period_d;
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            score_q    <= score_d;
        end
    end

    assign bus.out_update_tick = tick_q;
    assign bus.out_snake_reset = (state_q == ST_IDLE);
    assign bus.out_direction   = dir_q;
    assign bus.out_state       = state_q;
    assign bus.out_score       = score_q;

endmodule
